// File: rtl/fwts_pkg.sv
// Shared definitions for the four-way traffic signal controller and its safety monitor:
// light codes, fault codes and the per-axis check flag bundle.
package fwts_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [2:0] FLT_NONE         = 3'd0;
  localparam logic [2:0] FLT_ENCODING     = 3'd1;
  localparam logic [2:0] FLT_CONFLICT     = 3'd2;
  localparam logic [2:0] FLT_MISMATCH     = 3'd3;
  localparam logic [2:0] FLT_SEQUENCE     = 3'd4;
  localparam logic [2:0] FLT_SHORT_GREEN  = 3'd5;
  localparam logic [2:0] FLT_SHORT_YELLOW = 3'd6;
  localparam logic [2:0] FLT_TIMEOUT      = 3'd7;

  typedef struct packed {
    logic seq;
    logic short_green;
    logic short_yellow;
  } axis_flags_t;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YELLOW) || (code == LIGHT_GREEN);
  endfunction

  // hits[n] set means fault code n fired; the lowest code wins.
  function automatic logic [2:0] flt_encode(input logic [7:1] hits);
    logic [2:0] code;
    code = FLT_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (hits[i]) code = 3'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/fwts_axis_chk.sv
// Per-axis sequence and dwell checker: previous code, dwell counter, first-sample handling
// and the bad-sequence / short-green / short-yellow flags.
module fwts_axis_chk
  import fwts_pkg::*;
#(
  parameter int MIN_GREEN  = 10,
  parameter int MIN_YELLOW = 3,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  code,
  input  logic        legal,
  output axis_flags_t flags,
  output logic        changed,
  output logic        red_to_green
);

  logic [2:0]       prev_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic             first_reg;  // next sample is the first after reset
  logic             init_reg;   // still in the state whose start was not observed
  logic             check;
  logic             legal_step;

  assign changed      = !first_reg && (code != prev_reg);
  assign red_to_green = !first_reg && (prev_reg == LIGHT_RED) && (code == LIGHT_GREEN);
  assign check        = changed && legal;
  assign legal_step   = ((prev_reg == LIGHT_GREEN)  && (code == LIGHT_YELLOW)) ||
                        ((prev_reg == LIGHT_YELLOW) && (code == LIGHT_RED))    ||
                        ((prev_reg == LIGHT_RED)    && (code == LIGHT_GREEN));

  assign flags.seq          = check && is_legal(prev_reg) && !legal_step;
  assign flags.short_green  = check && !init_reg && (prev_reg == LIGHT_GREEN) &&
                              (dwell_reg < CNT_W'(MIN_GREEN));
  assign flags.short_yellow = check && !init_reg && (prev_reg == LIGHT_YELLOW) &&
                              (dwell_reg < CNT_W'(MIN_YELLOW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg  <= LIGHT_RED;
      dwell_reg <= '0;
      first_reg <= 1'b1;
      init_reg  <= 1'b1;
    end else if (first_reg) begin
      prev_reg  <= code;
      dwell_reg <= CNT_W'(1);
      first_reg <= 1'b0;
      init_reg  <= 1'b1;
    end else if (code != prev_reg) begin
      prev_reg  <= code;
      dwell_reg <= CNT_W'(1);
      init_reg  <= 1'b0;
    end else if (dwell_reg != '1) begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fwts_monitor.sv
// Safety monitor for the four-way traffic signal outputs with sticky first-fault reporting.
// Optional watchdog (fault code 7) is built only when FWTS_MON_TIMEOUT_EN is defined.
module fwts_monitor
  import fwts_pkg::*;
#(
  parameter int MIN_GREEN  = 10,
  parameter int MIN_YELLOW = 3,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       north,
  input  logic [2:0]       south,
  input  logic [2:0]       east,
  input  logic [2:0]       west,
  input  logic             clr,
  output logic             viol,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] ns_green_cnt
);

  logic [2:0]       dir [4];
  logic [3:0]       legal;
  axis_flags_t      ns_flags, ew_flags;
  logic             ns_chg, ew_chg, ns_r2g, ew_r2g;
  logic             illegal, conflict, mismatch, timeout_hit;
  logic [7:1]       hits;
  logic [2:0]       code_next;
  logic             any_viol;
  logic             viol_reg, fault_reg;
  logic [2:0]       code_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             unused_ok;

  assign dir[0] = north;
  assign dir[1] = south;
  assign dir[2] = east;
  assign dir[3] = west;

  for (genvar gi = 0; gi < 4; gi++) begin : g_legal
    assign legal[gi] = is_legal(dir[gi]);
  end

  assign illegal  = !(&legal);
  assign conflict = ((north != LIGHT_RED) || (south != LIGHT_RED)) &&
                    ((east  != LIGHT_RED) || (west  != LIGHT_RED));
  assign mismatch = (north != south) || (east != west);

  fwts_axis_chk #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_ns (
    .clk(clk), .rst(rst), .code(north), .legal(legal[0] && legal[1]),
    .flags(ns_flags), .changed(ns_chg), .red_to_green(ns_r2g)
  );

  fwts_axis_chk #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_ew (
    .clk(clk), .rst(rst), .code(east), .legal(legal[2] && legal[3]),
    .flags(ew_flags), .changed(ew_chg), .red_to_green(ew_r2g)
  );

`ifdef FWTS_MON_TIMEOUT_EN
  logic [CNT_W-1:0] wd_reg;

  // Fires on the TIMEOUT-th quiet cycle, then restarts from zero.
  assign timeout_hit = !ns_chg && !ew_chg && (wd_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_reg <= '0;
    end else if (ns_chg || ew_chg || timeout_hit) begin
      wd_reg <= '0;
    end else begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  assign unused_ok = &{1'b0, ew_r2g};
`else
  assign timeout_hit = 1'b0;
  // EW red->green and the change strobes have no consumer without the watchdog.
  assign unused_ok = &{1'b0, ew_r2g, ns_chg, ew_chg, TIMEOUT[0]};
`endif

  assign hits = {timeout_hit,
                 ns_flags.short_yellow | ew_flags.short_yellow,
                 ns_flags.short_green  | ew_flags.short_green,
                 ns_flags.seq          | ew_flags.seq,
                 mismatch, conflict, illegal};
  assign any_viol  = |hits;
  assign code_next = flt_encode(hits);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_reg  <= 1'b0;
      fault_reg <= 1'b0;
      code_reg  <= FLT_NONE;
      cnt_reg   <= '0;
    end else begin
      viol_reg <= any_viol;
      // A violation coinciding with clr replaces the old code.
      if (any_viol && (clr || !fault_reg)) begin
        fault_reg <= 1'b1;
        code_reg  <= code_next;
      end else if (clr) begin
        fault_reg <= 1'b0;
        code_reg  <= FLT_NONE;
      end
      if (ns_r2g) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign viol         = viol_reg;
  assign fault        = fault_reg;
  assign fault_code   = code_reg;
  assign ns_green_cnt = cnt_reg;

endmodule

// File: tb/tb_fwts_monitor.sv
// Directed scoreboard bench for fwts_monitor; expects TIMEOUT=50 behaviour when
// FWTS_MON_TIMEOUT_EN is defined, otherwise no watchdog faults.
module tb_fwts_monitor;
  import fwts_pkg::*;

`ifdef FWTS_MON_TIMEOUT_EN
  localparam int TO    = 50;
  localparam bit WD_ON = 1'b1;
`else
  localparam int TO    = 1000;
  localparam bit WD_ON = 1'b0;
`endif
  localparam int CW = 16;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    north = R, south = R, east = R, west = R;
  logic          clr = 1'b0;
  logic          viol, fault;
  logic [2:0]    fault_code;
  logic [CW-1:0] ns_green_cnt;

  typedef struct {
    logic          viol;
    logic          fault;
    logic [2:0]    code;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  fwts_monitor #(.MIN_GREEN(10), .MIN_YELLOW(3), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .north(north), .south(south), .east(east), .west(west),
    .clr(clr), .viol(viol), .fault(fault), .fault_code(fault_code),
    .ns_green_cnt(ns_green_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One sample: drive at negedge, push expectation, pop and compare after the edge.
  task automatic put(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                     input logic [2:0] w, input logic c, input logic ev,
                     input logic [2:0] ecode, input string tag);
    exp_t x;
    north = n; south = s; east = e; west = w; clr = c;
    sb.push_back('{ev, (ecode != 3'd0), ecode, exp_cnt[CW-1:0], tag});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".viol"},  {31'd0, viol},       {31'd0, x.viol});
    chk({x.tag, ".fault"}, {31'd0, fault},      {31'd0, x.fault});
    chk({x.tag, ".code"},  {29'd0, fault_code}, {29'd0, x.code});
    chk({x.tag, ".cnt"},   {16'd0, ns_green_cnt}, {16'd0, x.cnt});
    $display("txn %-14s n=%b s=%b e=%b w=%b clr=%b -> viol=%b fault=%b code=%0d cnt=%0d",
             tag, n, s, e, w, c, viol, fault, fault_code, ns_green_cnt);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int k,
                      input logic [2:0] ecode, input string tag);
    for (int i = 0; i < k; i++) put(ns, ns, ew, ew, 1'b0, 1'b0, ecode, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, ".rst_viol"},  {31'd0, viol},         32'd0);
    chk({tag, ".rst_fault"}, {31'd0, fault},        32'd0);
    chk({tag, ".rst_code"},  {29'd0, fault_code},   32'd0);
    chk({tag, ".rst_cnt"},   {16'd0, ns_green_cnt}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".rst_hold"}, {28'd0, viol, fault, fault_code} , 32'd0);
    $display("txn %-14s reset -> viol=%b fault=%b code=%0d cnt=%0d",
             tag, viol, fault, fault_code, ns_green_cnt);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #3;
    // Legal cycle, three rounds
    do_reset("reset");
    hold(R, R, 1, 3'd0, "first");
    for (int r = 0; r < 3; r++) begin
      exp_cnt++;
      hold(G, R, 10, 3'd0, "ns_green");
      hold(Y, R, 3,  3'd0, "ns_yellow");
      hold(R, G, 10, 3'd0, "ew_green");
      hold(R, Y, 3,  3'd0, "ew_yellow");
      hold(R, R, 1,  3'd0, "all_red");
    end
    chk("legal.cnt3", {16'd0, ns_green_cnt}, 32'd3);

    // Conflict, then a short yellow that must not overwrite code 2
    do_reset("rst_conf");
    hold(R, R, 1, 3'd0, "first");
    exp_cnt = 1;
    put(G, G, G, G, 1'b0, 1'b1, FLT_CONFLICT, "conflict");
    put(Y, Y, R, R, 1'b0, 1'b1, FLT_CONFLICT, "after_conf");
    put(R, R, R, R, 1'b0, 1'b1, FLT_CONFLICT, "short_y_keep");
    hold(R, R, 2, FLT_CONFLICT, "sticky");

    // Short yellow, then clear
    do_reset("rst_sy");
    hold(R, R, 1, 3'd0, "first");
    exp_cnt = 1;
    hold(G, R, 10, 3'd0, "ns_green");
    hold(Y, R, 2,  3'd0, "ns_yellow2");
    put(R, R, R, R, 1'b0, 1'b1, FLT_SHORT_YELLOW, "short_yellow");
    put(R, R, R, R, 1'b1, 1'b0, 3'd0, "clr");
    put(R, R, R, R, 1'b0, 1'b0, 3'd0, "after_clr");

    // Illegal encoding beats bad sequence; clr with a new violation loads the new code
    do_reset("rst_prio");
    hold(R, R, 1, 3'd0, "first");
    exp_cnt = 1;
    hold(G, R, 10, 3'd0, "ns_green");
    put(R, R, R, 3'b011, 1'b0, 1'b1, FLT_ENCODING, "prio");
    exp_cnt = 2;
    put(G, R, R, R, 1'b1, 1'b1, FLT_MISMATCH, "clr_vs_new");

    // Reset during NS yellow: first-state duration suppression
    do_reset("rst_mid0");
    hold(R, R, 1, 3'd0, "first");
    exp_cnt = 1;
    hold(G, R, 10, 3'd0, "ns_green");
    hold(Y, R, 2,  3'd0, "ns_yellow");
    do_reset("rst_mid");
    put(Y, Y, R, R, 1'b0, 1'b0, 3'd0, "first_y");
    put(R, R, R, R, 1'b0, 1'b0, 3'd0, "suppressed");
    put(R, R, R, R, 1'b0, 1'b0, 3'd0, "quiet");

    // Watchdog: constant codes
    do_reset("rst_wd");
    for (int i = 1; i <= 52; i++) begin
      put(R, R, R, R, 1'b0, (WD_ON && i == TO), ((WD_ON && i >= TO) ? FLT_TIMEOUT : 3'd0),
          "hold_const");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
